// File: rtl/button_debouncer.sv
// button_debouncer
//   Per-bit two-flop synchroniser followed by an independent STABLE/COUNTING
//   debounce FSM per button bit. BTN_CLEAN changes only after the synchronised
//   input has held its new level for DEBOUNCE_CYCLES consecutive HCLK cycles.
//
//   Optional feature macro: BUTTON_DEBOUNCE_EDGE_EN
//     defined     : BTN_PRESS / BTN_RELEASE give registered one-cycle pulses,
//                   aligned with the change of BTN_CLEAN.
//     not defined : no pulse registers; BTN_PRESS / BTN_RELEASE are tied to 0.
//
//   Handshake: there is none. BTN_CLEAN is a level, and the pulses are
//   qualifiers that are valid for exactly the one cycle in which BTN_CLEAN
//   changes. No consumer back-pressure exists.
module button_debouncer #(
    parameter int NBTN            = 8,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic            HCLK,
    input  logic            HRESETn,
    input  logic [NBTN-1:0] BTN_RAW,
    output logic [NBTN-1:0] BTN_CLEAN,
    output logic [NBTN-1:0] BTN_PRESS,
    output logic [NBTN-1:0] BTN_RELEASE
);

    typedef enum logic {
        STABLE   = 1'b0,
        COUNTING = 1'b1
    } state_t;

    // The cycle in which STABLE first sees the mismatch already counts as one
    // stable cycle, so COUNTING only needs DEBOUNCE_CYCLES-1 further cycles:
    // cnt runs 0 .. DEBOUNCE_CYCLES-2 and commits on that last value. This
    // puts the BTN_CLEAN update at edge DEBOUNCE_CYCLES+2 after the raw change.
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 2);

    logic [NBTN-1:0]  sync1;
    logic [NBTN-1:0]  sync2;
    logic [NBTN-1:0]  clean_q;
    logic [NBTN-1:0]  clean_d;
    state_t           state_q [NBTN];
    state_t           state_d [NBTN];
    logic [CNT_W-1:0] cnt_q   [NBTN];
    logic [CNT_W-1:0] cnt_d   [NBTN];

    // Two-flop synchroniser chain, nothing between the flops.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= BTN_RAW;
            sync2 <= sync1;
        end
    end

    // Per-bit FSM next state, counter and clean-level update.
    always_comb begin
        clean_d = clean_q;
        for (int i = 0; i < NBTN; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                STABLE: begin
                    if (sync2[i] != clean_q[i]) begin
                        state_d[i] = COUNTING;
                    end
                end
                COUNTING: begin
                    if (sync2[i] == clean_q[i]) begin
                        // Bounced back to the old level: restart from zero.
                        state_d[i] = STABLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_TERM) begin
                        clean_d[i] = sync2[i];
                        state_d[i] = STABLE;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                default: begin
                    state_d[i] = STABLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // FSM state, counters and the clean output register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            clean_q <= '0;
            for (int i = 0; i < NBTN; i++) begin
                state_q[i] <= STABLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            clean_q <= clean_d;
            for (int i = 0; i < NBTN; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign BTN_CLEAN = clean_q;

`ifdef BUTTON_DEBOUNCE_EDGE_EN
    logic [NBTN-1:0] press_q;
    logic [NBTN-1:0] release_q;

    // Edge pulses taken from the next clean value so they line up with BTN_CLEAN.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            press_q   <= '0;
            release_q <= '0;
        end else begin
            press_q   <= clean_d & ~clean_q;
            release_q <= ~clean_d & clean_q;
        end
    end

    assign BTN_PRESS   = press_q;
    assign BTN_RELEASE = release_q;
`else
    assign BTN_PRESS   = '0;
    assign BTN_RELEASE = '0;
`endif

endmodule
